tx_arbiter: RTL



---
 rtl/tx_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/tx_arbiter.sv
// Arbitrates trigger/ch1/ch2 onto one byte-wide transmit path and serialises each word MSB-first.
// Define TX_ARBITER_HEADER_EN to prefix every granted frame with a one-beat stream-id header.
module tx_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TX_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tr_data,
  input  logic                  tr_rdy,
  output logic                  tr_ack,
  input  logic                  tr_eof,
  input  logic [DATA_WIDTH-1:0] ch1_data,
  input  logic                  ch1_rdy,
  output logic                  ch1_ack,
  input  logic                  ch1_eof,
  input  logic [DATA_WIDTH-1:0] ch2_data,
  input  logic                  ch2_rdy,
  output logic                  ch2_ack,
  input  logic                  ch2_eof,
  output logic [TX_WIDTH-1:0]   tx_data,
  output logic                  tx_rdy,
  input  logic                  tx_ack,
  output logic [1:0]            grant,
  output logic                  busy
);

  localparam int unsigned NumBeats = DATA_WIDTH / TX_WIDTH;
  localparam int unsigned CntW     = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(NumBeats - 1);

  localparam logic [1:0] GntNone = 2'd0;
  localparam logic [1:0] GntTr   = 2'd1;
  localparam logic [1:0] GntCh1  = 2'd2;
  localparam logic [1:0] GntCh2  = 2'd3;

`ifdef TX_ARBITER_HEADER_EN
  typedef enum logic [1:0] {StIdle, StHeader, StLoad, StShift} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;
`endif

  state_e                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  rr_q, rr_d;  // 0: ch1 wins the next tie, 1: ch2 wins
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [TX_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                  tx_rdy_q, tx_rdy_d;
  logic [2:0]            ack_q, ack_d;
  logic                  busy_q, busy_d;

  logic                  sel_rdy;
  logic                  sel_eof;
  logic [DATA_WIDTH-1:0] sel_data;

  always_comb begin
    sel_rdy  = 1'b0;
    sel_eof  = 1'b0;
    sel_data = '0;
    case (grant_q)
      GntTr: begin
        sel_rdy  = tr_rdy;
        sel_eof  = tr_eof;
        sel_data = tr_data;
      end
      GntCh1: begin
        sel_rdy  = ch1_rdy;
        sel_eof  = ch1_eof;
        sel_data = ch1_data;
      end
      GntCh2: begin
        sel_rdy  = ch2_rdy;
        sel_eof  = ch2_eof;
        sel_data = ch2_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tx_rdy_d  = tx_rdy_q;
    ack_d     = 3'b000;

    case (state_q)
      StIdle: begin
        if (tr_rdy) begin
          grant_d = GntTr;
        end else if (ch1_rdy && (!ch2_rdy || !rr_q)) begin
          grant_d = GntCh1;
          rr_d    = ~rr_q;
        end else if (ch2_rdy) begin
          grant_d = GntCh2;
          rr_d    = ~rr_q;
        end
        if (tr_rdy || ch1_rdy || ch2_rdy) begin
`ifdef TX_ARBITER_HEADER_EN
          state_d   = StHeader;
          tx_data_d = TX_WIDTH'(grant_d);
          tx_rdy_d  = 1'b1;
`else
          state_d   = StLoad;
`endif
        end
      end
`ifdef TX_ARBITER_HEADER_EN
      StHeader: begin
        if (tx_ack && tx_rdy_q) begin
          tx_rdy_d = 1'b0;
          state_d  = StLoad;
        end
      end
`endif
      StLoad: begin
        // A pending word always beats eof, so a late eof is seen on the next visit.
        if (sel_rdy) begin
          shreg_d   = sel_data << TX_WIDTH;
          tx_data_d = sel_data[DATA_WIDTH-1 -: TX_WIDTH];
          tx_rdy_d  = 1'b1;
          cnt_d     = '0;
          ack_d     = 3'b001 << (grant_q - 2'd1);
          state_d   = StShift;
        end else if (sel_eof) begin
          grant_d = GntNone;
          state_d = StIdle;
        end
      end
      StShift: begin
        if (tx_ack && tx_rdy_q) begin
          if (cnt_q == LastBeat) begin
            tx_rdy_d = 1'b0;
            cnt_d    = '0;
            state_d  = StLoad;
          end else begin
            cnt_d     = cnt_q + CntW'(1);
            tx_data_d = shreg_q[DATA_WIDTH-1 -: TX_WIDTH];
            shreg_d   = shreg_q << TX_WIDTH;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      grant_q   <= GntNone;
      rr_q      <= 1'b0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_rdy_q  <= 1'b0;
      ack_q     <= 3'b000;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_rdy_q  <= tx_rdy_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_data = tx_data_q;
  assign tx_rdy  = tx_rdy_q;
  assign tr_ack  = ack_q[0];
  assign ch1_ack = ack_q[1];
  assign ch2_ack = ack_q[2];
  assign grant   = grant_q;
  assign busy    = busy_q;

endmodule
